// File: rtl/pu_riscv_biu_arbiter_if.sv
// pu_riscv_biu_arbiter_if: requester-side and bridge-side BIU signal bundle around the arbiter.
// slave = arbiter view; master = core units plus bridge view.
interface pu_riscv_biu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_stb_i;
  logic [NREQ-1:0]      req_stb_ack_o;
  logic [NREQ-1:0]      req_d_ack_o;
  logic [NREQ*PLEN-1:0] req_adri_i;
  logic [NREQ*3-1:0]    req_size_i;
  logic [NREQ*3-1:0]    req_type_i;
  logic [NREQ*3-1:0]    req_prot_i;
  logic [NREQ-1:0]      req_lock_i;
  logic [NREQ-1:0]      req_we_i;
  logic [NREQ*XLEN-1:0] req_d_i;
  logic [XLEN-1:0]      req_q_o;
  logic [NREQ-1:0]      req_ack_o;
  logic [NREQ-1:0]      req_err_o;
  logic                 bb_stb_o;
  logic [PLEN-1:0]      bb_adri_o;
  logic [2:0]           bb_size_o;
  logic [2:0]           bb_type_o;
  logic [2:0]           bb_prot_o;
  logic                 bb_lock_o;
  logic                 bb_we_o;
  logic [XLEN-1:0]      bb_d_o;
  logic                 bb_stb_ack_i;
  logic                 bb_d_ack_i;
  logic                 bb_ack_i;
  logic                 bb_err_i;
  logic [XLEN-1:0]      bb_q_i;

  modport slave (
    input  req_stb_i, req_adri_i, req_size_i, req_type_i, req_prot_i, req_lock_i, req_we_i, req_d_i,
    output req_stb_ack_o, req_d_ack_o, req_q_o, req_ack_o, req_err_o,
    output bb_stb_o, bb_adri_o, bb_size_o, bb_type_o, bb_prot_o, bb_lock_o, bb_we_o, bb_d_o,
    input  bb_stb_ack_i, bb_d_ack_i, bb_ack_i, bb_err_i, bb_q_i
  );

  modport master (
    output req_stb_i, req_adri_i, req_size_i, req_type_i, req_prot_i, req_lock_i, req_we_i, req_d_i,
    input  req_stb_ack_o, req_d_ack_o, req_q_o, req_ack_o, req_err_o,
    input  bb_stb_o, bb_adri_o, bb_size_o, bb_type_o, bb_prot_o, bb_lock_o, bb_we_o, bb_d_o,
    output bb_stb_ack_i, bb_d_ack_i, bb_ack_i, bb_err_i, bb_q_i
  );
endinterface

// File: rtl/pu_riscv_biu_arbiter.sv
// pu_riscv_biu_arbiter: grants one of NREQ BIU requesters the bridge bus until its beats drain and lock drops.
// Define PU_RISCV_BIU_ARB_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module pu_riscv_biu_arbiter #(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter int NREQ = 2
) (
  input logic HCLK,
  input logic HRESETn,
  pu_riscv_biu_arbiter_if.slave bus_if
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, win;
  logic [5:0]    beats_q, beats_d, len;
  logic [6:0]    sum;
  logic          any_req, in_grant, own_stb, own_lock, rel;

  function automatic logic [5:0] burst_len(input logic [2:0] t);
    return t[2:1] == 2'b11 ? 6'd16 : t[2:1] == 2'b10 ? 6'd8 : t[2:1] == 2'b01 ? 6'd4 : 6'd1;
  endfunction

  assign any_req  = |bus_if.req_stb_i;
  assign in_grant = state_q == GRANT;
  assign own_stb  = bus_if.req_stb_i[gnt_q];
  assign own_lock = bus_if.req_lock_i[gnt_q];

  assign bus_if.bb_stb_o  = in_grant & own_stb;
  assign bus_if.bb_adri_o = bus_if.req_adri_i[gnt_q*PLEN +: PLEN];
  assign bus_if.bb_size_o = bus_if.req_size_i[gnt_q*3 +: 3];
  assign bus_if.bb_type_o = bus_if.req_type_i[gnt_q*3 +: 3];
  assign bus_if.bb_prot_o = bus_if.req_prot_i[gnt_q*3 +: 3];
  assign bus_if.bb_lock_o = own_lock;
  assign bus_if.bb_we_o   = bus_if.req_we_i[gnt_q];
  assign bus_if.bb_d_o    = bus_if.req_d_i[gnt_q*XLEN +: XLEN];
  assign bus_if.req_q_o   = bus_if.bb_q_i;

  always_comb begin
    bus_if.req_stb_ack_o = '0;
    bus_if.req_d_ack_o   = '0;
    bus_if.req_ack_o     = '0;
    bus_if.req_err_o     = '0;
    if (in_grant) begin
      bus_if.req_stb_ack_o[gnt_q] = bus_if.bb_stb_ack_i;
      bus_if.req_d_ack_o[gnt_q]   = bus_if.bb_d_ack_i;
      bus_if.req_ack_o[gnt_q]     = bus_if.bb_ack_i;
      bus_if.req_err_o[gnt_q]     = bus_if.bb_err_i;
    end
  end

  // Bridge handshakes outside GRANT are protocol violations and leave the count untouched.
  assign len = burst_len(bus_if.bb_type_o);
  always_comb begin
    sum     = {1'b0, beats_q} + (bus_if.bb_stb_ack_i ? {1'b0, len} : 7'd0);
    beats_d = beats_q;
    if (in_grant)
      beats_d = bus_if.bb_err_i ? 6'd0 : (bus_if.bb_ack_i && sum != 7'd0) ? 6'(sum - 7'd1) : sum[5:0];
  end

  assign rel     = in_grant & ~own_stb & (beats_d == 6'd0) & ~own_lock;
  assign state_d = in_grant ? (rel ? IDLE : GRANT) : (any_req ? GRANT : IDLE);
  assign gnt_d   = (!in_grant && any_req) ? win : gnt_q;

`ifdef PU_RISCV_BIU_ARB_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (bus_if.req_stb_i[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] rr_q, rr_d;

  // Lowest requester at or above rr_q wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (bus_if.req_stb_i[i]) win = IW'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (bus_if.req_stb_i[i] && IW'(i) >= rr_q) win = IW'(i);
  end

  assign rr_d = rel ? (gnt_q == IW'(NREQ - 1) ? '0 : gnt_q + 1'b1) : rr_q;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rr_q <= '0;
    else rr_q <= rr_d;
`endif

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beats_q <= beats_d;
    end
endmodule
